// File: rtl/truth_table_capture.sv
// truth_table_capture: sweeps every N_IN-bit vector in ascending order into a
// combinational DUT. Each vector is held for SETTLE cycles, then the DUT output
// is sampled for one cycle into table_out. The captured table is compared bit
// by bit against EXPECTED. The block reports a mismatch count and a pass flag.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         starts a sweep; only sampled in IDLE
//   dut_out       DUT output under test; only sampled in SAMPLE
//   vec           vector driven to the DUT (MSB = first DUT input)
//   busy          sweep in progress (SETTLE/SAMPLE)
//   done          one-cycle pulse after the sweep completes
//   table_out     captured truth table, bit i = sample for vector i
//   mismatch_cnt  number of bits where table_out differs from EXPECTED
//   pass          last completed sweep had no mismatches
//
// Optional feature macro: STOP_ON_FAIL_EN. When it is defined, the first
// mismatching sample ends the sweep, and vec keeps the failing index until the
// next start.
module truth_table_capture #(
  parameter int unsigned           N_IN     = 4,
  parameter int unsigned           SETTLE   = 2,
  parameter logic [2**N_IN-1:0]    EXPECTED = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                dut_out,
  output logic [N_IN-1:0]     vec,
  output logic                busy,
  output logic                done,
  output logic [2**N_IN-1:0]  table_out,
  output logic [N_IN:0]       mismatch_cnt,
  output logic                pass
);

  localparam int unsigned NVEC  = 2**N_IN;
  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [N_IN-1:0]  VEC_LAST = N_IN'(NVEC - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

`ifdef STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic             miss_c;

  // The current sample disagrees with the expected table entry.
  assign miss_c = (dut_out != EXPECTED[vec]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_SETTLE;
      S_SETTLE: if (cnt == '0) state_next = S_SAMPLE;
      S_SAMPLE: begin
        if ((vec == VEC_LAST) || (STOP && miss_c)) state_next = S_DONE;
        else                                      state_next = S_SETTLE;
      end
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      table_out    <= '0;
      mismatch_cnt <= '0;
      pass         <= 1'b0;
      cnt          <= '0;
    end else begin
      busy <= (state_next == S_SETTLE) || (state_next == S_SAMPLE);
      // done lands in the cycle after DONE, alongside the updated pass flag.
      done <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            table_out    <= '0;
            mismatch_cnt <= '0;
            pass         <= 1'b0;
            vec          <= '0;
            cnt          <= CNT_LOAD;
          end
        end
        S_SETTLE: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        S_SAMPLE: begin
          table_out[vec] <= dut_out;
          if (miss_c) mismatch_cnt <= mismatch_cnt + 1'b1;
          if (state_next == S_SETTLE) begin
            vec <= vec + 1'b1;
            cnt <= CNT_LOAD;
          end
        end
        S_DONE: begin
          pass <= (mismatch_cnt == '0);
          // An early stop keeps the failing index visible; otherwise rewind.
          if (!(STOP && (mismatch_cnt != '0))) vec <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
